bbox_scanner: RTL



---
 rtl/bbox_scanner.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bbox_scanner.sv
// Bounding-box scanner: tracks the extent of non-background pixels in one
// raster-ordered frame and presents xMin/xMax/yMin/yMax with a done pulse.
module bbox_scanner #(
  parameter int unsigned WIDTH  = 640,
  parameter int unsigned HEIGHT = 480,
  parameter logic [7:0]  BG     = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [7:0]  px_data,
  output logic        done,
  output logic        empty,
  output logic [10:0] xMin,
  output logic [10:0] xMax,
  output logic [10:0] yMin,
  output logic [10:0] yMax,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
  localparam logic [10:0] Y_LAST = 11'(HEIGHT - 1);

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        found_q, found_d;
  logic [10:0] tx_min_q, tx_min_d, tx_max_q, tx_max_d;
  logic [10:0] ty_min_q, ty_min_d, ty_max_q, ty_max_d;
  logic        accept, last_px;

  // Handshake: a pixel transfers on a rising edge where px_valid && px_ready;
  // px_ready depends only on registered state, never on px_valid.
  assign px_ready  = (state_q == SCAN);
  assign done      = (state_q == FINISH);
  assign dbg_state = state_q;
  assign accept    = px_valid && px_ready;
  assign last_px   = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    found_d  = found_q;
    tx_min_d = tx_min_q;
    tx_max_d = tx_max_q;
    ty_min_d = ty_min_q;
    ty_max_d = ty_max_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = '0;
          y_d     = '0;
          found_d = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (accept) begin
          if (px_data != BG) begin
            found_d = 1'b1;
            if (!found_q) begin
              tx_min_d = x_q;
              tx_max_d = x_q;
              ty_min_d = y_q;
              ty_max_d = y_q;
            end else begin
              // Raster order: first hit fixes yMin, every later hit is the new yMax.
              if (x_q < tx_min_q) tx_min_d = x_q;
              if (x_q > tx_max_q) tx_max_d = x_q;
              ty_max_d = y_q;
            end
          end
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + 11'd1;
          end else begin
            x_d = x_q + 11'd1;
          end
          if (last_px) state_d = FINISH;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      found_q  <= 1'b0;
      tx_min_q <= '0;
      tx_max_q <= '0;
      ty_min_q <= '0;
      ty_max_q <= '0;
      empty    <= 1'b0;
      xMin     <= '0;
      xMax     <= '0;
      yMin     <= '0;
      yMax     <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      found_q  <= found_d;
      tx_min_q <= tx_min_d;
      tx_max_q <= tx_max_d;
      ty_min_q <= ty_min_d;
      ty_max_q <= ty_max_d;
      // Outputs load on the edge into FINISH so they are valid with done.
      if (accept && last_px) begin
        empty <= ~found_d;
        xMin  <= found_d ? tx_min_d : 11'd0;
        xMax  <= found_d ? tx_max_d : 11'd0;
        yMin  <= found_d ? ty_min_d : 11'd0;
        yMax  <= found_d ? ty_max_d : 11'd0;
      end
    end
  end

endmodule
